spi_rx_collector: RTL

- Downstream consumer of the SPI slave receive stage.
- Detects each completed 12-bit frame from the slave's done/dout outputs, brings it into the clk domain, and buffers it in a FIFO.
- Presents buffered words on a valid/ready stream to the system side. Tracks fill level, accepted-frame count and a sticky overflow.

---
 rtl/spi_rx_collector_if.sv | 27 ++
 rtl/spi_rx_collector.sv | 82 ++++++++
 2 files changed

// File: rtl/spi_rx_collector_if.sv
// Stream and status bundle between the SPI slave receive stage, the collector and the system side.
// The slave modport is the collector's view; master is the surrounding logic.
interface spi_rx_collector_if #(
  parameter int DW    = 12,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
);
  logic                       done;
  logic [DW-1:0]              dout;
  logic [DW-1:0]              m_data;
  logic                       m_valid;
  logic                       m_ready;
  logic [$clog2(DEPTH+1)-1:0] level;
  logic [CNT_W-1:0]           frame_cnt;
  logic                       overflow;
  logic                       clr_ovf;

  modport master (
    output done, dout, m_ready, clr_ovf,
    input  m_data, m_valid, level, frame_cnt, overflow
  );

  modport slave (
    input  done, dout, m_ready, clr_ovf,
    output m_data, m_valid, level, frame_cnt, overflow
  );
endinterface

// File: rtl/spi_rx_collector.sv
// Captures each completed SPI slave frame, resynchronises it into clk and buffers it
// in a small FIFO drained over valid/ready; tracks fill level, frame count and overflow.
module spi_rx_collector #(
  parameter int DW    = 12,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input logic                clk,
  input logic                rst,
  spi_rx_collector_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic          d1, d2, done_prev;
  logic [DW-1:0] q1, q2;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_q;
  logic [CNT_W-1:0] cnt_q;
  logic          ovf_q;
  logic          capture, pop, push;

  // done and dout share the same two-stage chain so the captured word matches the flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d1        <= 1'b0;
      d2        <= 1'b0;
      done_prev <= 1'b0;
      q1        <= '0;
      q2        <= '0;
    end else begin
      d1        <= bus.done;
      d2        <= d1;
      done_prev <= d2;
      q1        <= bus.dout;
      q2        <= q1;
    end
  end

  assign capture = d2 & ~done_prev;
  assign pop     = bus.m_valid & bus.m_ready;
  assign push    = capture & ((level_q < LW'(DEPTH)) | pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= q2;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      if (push) cnt_q <= cnt_q + CNT_W'(1);
      // a drop in the same cycle as a clear keeps the flag set
      if (capture & ~push)   ovf_q <= 1'b1;
      else if (bus.clr_ovf)  ovf_q <= 1'b0;
    end
  end

  assign bus.m_data    = mem[rd_ptr];
  assign bus.m_valid   = (level_q != '0);
  assign bus.level     = level_q;
  assign bus.frame_cnt = cnt_q;
  assign bus.overflow  = ovf_q;
endmodule
